// File: rtl/ddr_rx_word_aligner_pkg.sv
// ddr_rx_pkg: shared types and defaults for the DDR receive word aligner
//   rx_state_t     : aligner FSM state (HUNT for sync, LOCKED to word boundary)
//   DEF_SYNC_WORD  : default alignment/idle pattern, never emitted as data
//   DEF_DATA_W     : default output word width
//   DEF_CNT_W      : default overflow counter width
package ddr_rx_pkg;
  typedef enum logic {RX_HUNT, RX_LOCKED} rx_state_t;
  localparam logic [7:0] DEF_SYNC_WORD = 8'hA5;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_CNT_W = 8;
endpackage

// File: rtl/ddr_rx_word_aligner_if.sv
// ddr_rx_word_aligner_if: valid/ready word bus from the aligner to the RX FIFO
//   out_valid : out_data holds an unconsumed word (master drives)
//   out_data  : DATA_W-bit word, bit 0 = earliest received bit (master drives)
//   out_ready : consumer accepts when out_valid & out_ready (slave drives)
interface ddr_rx_word_aligner_if #(parameter int DATA_W = 8);
  logic out_valid;
  logic [DATA_W-1:0] out_data;
  logic out_ready;
  modport master (output out_valid, output out_data, input out_ready);
  modport slave (input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/ddr_rx_word_aligner_hold_reg.sv
// ddr_rx_hold_reg: single-entry valid/ready holding register feeding the word bus
//   clk, reset_n : clock, async active-low reset
//   i_load       : capture i_data this cycle (caller only loads when o_free)
//   i_data       : word to capture
//   o_free       : entry empty, or being accepted this cycle
//   out_if       : master side of the word bus
module ddr_rx_hold_reg #(parameter int DATA_W = 8) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_load,
  input  logic [DATA_W-1:0] i_data,
  output logic o_free,
  ddr_rx_word_aligner_if.master out_if
);
  logic r_valid;
  logic [DATA_W-1:0] r_data;
  assign o_free = !r_valid || out_if.out_ready;
  assign out_if.out_valid = r_valid;
  assign out_if.out_data = r_data;
  // A load in the accept cycle keeps valid high for full throughput
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid <= 1'b0;
      r_data <= '0;
    end else begin
      r_valid <= i_load || (r_valid && !out_if.out_ready);
      if (i_load) r_data <= i_data;
    end
  end
endmodule

// File: rtl/ddr_rx_word_aligner.sv
// ddr_rx_word_aligner: hunts for SYNC_WORD in a 2-bit DDR sample stream, packs aligned words, drops sync/idle words
//   clk, reset_n : clock, async active-low reset
//   i_in_valid   : i_ddr_in holds a valid sample pair
//   i_ddr_in     : [0] rising-edge (earlier) bit, [1] falling-edge bit
//   i_resync     : pulse, drop lock and clear the overflow flag
//   out_if       : valid/ready word bus towards the RX FIFO
//   o_locked     : aligned to a word boundary
//   o_sync_seen  : one-cycle pulse per SYNC_WORD matched
//   o_overflow   : sticky, a data word was dropped
//   o_ovf_count  : saturating count of dropped words
module ddr_rx_word_aligner
  import ddr_rx_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter logic [DATA_W-1:0] SYNC_WORD = DATA_W'(DEF_SYNC_WORD),
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_in_valid,
  input  logic [1:0] i_ddr_in,
  input  logic i_resync,
  ddr_rx_word_aligner_if.master out_if,
  output logic o_locked,
  output logic o_sync_seen,
  output logic o_overflow,
  output logic [CNT_W-1:0] o_ovf_count
);
  localparam int PH_W = $clog2(DATA_W / 2) < 1 ? 1 : $clog2(DATA_W / 2);
  localparam logic [PH_W-1:0] LAST = PH_W'(DATA_W / 2 - 1);
  rx_state_t r_state;
  logic [DATA_W-3:0] r_win;
  logic [PH_W-1:0] r_phase;
  logic r_sync_seen, r_overflow;
  logic [CNT_W-1:0] r_ovf_count;
  logic [DATA_W-1:0] w_win_next;
  logic w_is_sync, w_word_done, w_sync_hit, w_free, w_load, w_drop;
  // Only the newest DATA_W-2 bits need storing; the oldest pair falls out on every shift
  assign w_win_next = {i_ddr_in[1], i_ddr_in[0], r_win};
  assign w_is_sync = w_win_next == SYNC_WORD;
  assign w_word_done = r_state == RX_LOCKED && i_in_valid && r_phase == LAST;
  // resync wins over anything completing in the same cycle
  assign w_sync_hit = i_in_valid && w_is_sync && !i_resync && (r_state == RX_HUNT || w_word_done);
  assign w_load = w_word_done && !w_is_sync && !i_resync && w_free;
  assign w_drop = w_word_done && !w_is_sync && !i_resync && !w_free;
  assign o_locked = r_state == RX_LOCKED;
  assign o_sync_seen = r_sync_seen;
  assign o_overflow = r_overflow;
  assign o_ovf_count = r_ovf_count;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= RX_HUNT;
      r_win <= '0;
      r_phase <= '0;
      r_sync_seen <= 1'b0;
      r_overflow <= 1'b0;
      r_ovf_count <= '0;
    end else begin
      if (i_in_valid) r_win <= w_win_next[DATA_W-1:2];
      r_sync_seen <= w_sync_hit;
      if (i_resync) begin
        r_state <= RX_HUNT;
        r_phase <= '0;
        r_overflow <= 1'b0;
      end else if (i_in_valid) begin
        if (r_state == RX_HUNT) begin
          r_state <= w_is_sync ? RX_LOCKED : RX_HUNT;
          r_phase <= '0;
        end else r_phase <= w_word_done ? '0 : r_phase + PH_W'(1);
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
        r_ovf_count <= &r_ovf_count ? r_ovf_count : r_ovf_count + CNT_W'(1);
      end
    end
  end
  ddr_rx_hold_reg #(.DATA_W(DATA_W)) u_hold (
    .clk(clk),
    .reset_n(reset_n),
    .i_load(w_load),
    .i_data(w_win_next),
    .o_free(w_free),
    .out_if(out_if)
  );
endmodule

// File: tb/tb_ddr_rx_word_aligner.sv
// tb_ddr_rx_word_aligner: directed + randomized bench with a bit-stream reference model
module tb_ddr_rx_word_aligner;
  localparam logic [7:0] SYNC = 8'hA5;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic in_valid = 1'b0;
  logic resync = 1'b0;
  logic [1:0] ddr_in = 2'b00;
  logic locked, sync_seen, overflow;
  logic [7:0] ovf_count;
  ddr_rx_word_aligner_if #(.DATA_W(8)) bus();
  ddr_rx_word_aligner #(.DATA_W(8), .SYNC_WORD(8'hA5), .CNT_W(8)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .i_in_valid(in_valid),
    .i_ddr_in(ddr_in),
    .i_resync(resync),
    .out_if(bus),
    .o_locked(locked),
    .o_sync_seen(sync_seen),
    .o_overflow(overflow),
    .o_ovf_count(ovf_count)
  );
  always #5 clk = ~clk;
  int n_cmp = 0;
  int n_err = 0;
  int n_sync = 0;
  logic [7:0] got_q[$];
  logic [7:0] sent_q[$];
  bit m_hist[$];
  bit m_wbits[$];
  bit m_locked, m_full, m_ovf, m_sync;
  logic [7:0] m_data;
  int m_cnt;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_cmp++;
    assert (obs === want) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask
  function automatic logic [7:0] hist_val();
    logic [7:0] v = '0;
    for (int i = 0; i < 8; i++) v[i] = m_hist[i];
    return v;
  endfunction
  task automatic model_reset();
    m_hist.delete();
    for (int i = 0; i < 8; i++) m_hist.push_back(1'b0);
    m_wbits.delete();
    m_locked = 0; m_full = 0; m_ovf = 0; m_sync = 0; m_data = '0; m_cnt = 0;
  endtask
  task automatic model_edge(input logic iv, input logic [1:0] d, input logic rs, input logic rdy);
    bit acc = m_full && rdy;
    bit ld = 0;
    logic [7:0] w = '0;
    m_sync = 0;
    if (iv) begin
      m_hist.push_back(d[0]);
      m_hist.push_back(d[1]);
      while (m_hist.size() > 8) void'(m_hist.pop_front());
    end
    if (rs) begin
      m_locked = 0;
      m_wbits.delete();
      m_ovf = 0;
    end else if (iv) begin
      if (!m_locked) begin
        if (hist_val() == SYNC) begin
          m_sync = 1;
          m_locked = 1;
          m_wbits.delete();
        end
      end else begin
        m_wbits.push_back(d[0]);
        m_wbits.push_back(d[1]);
        if (m_wbits.size() == 8) begin
          for (int i = 0; i < 8; i++) w[i] = m_wbits[i];
          m_wbits.delete();
          if (w == SYNC) m_sync = 1;
          else if (!m_full || acc) ld = 1;
          else begin
            m_ovf = 1;
            if (m_cnt < 255) m_cnt++;
          end
        end
      end
    end
    if (ld) begin
      m_full = 1;
      m_data = w;
    end else if (acc) m_full = 0;
  endtask
  task automatic step(input logic iv, input logic [1:0] d, input logic rs, input logic rdy);
    @(negedge clk);
    in_valid = iv; ddr_in = d; resync = rs; bus.out_ready = rdy;
    #1;
    if (bus.out_valid && rdy) got_q.push_back(bus.out_data);
    @(posedge clk);
    model_edge(iv, d, rs, rdy);
    #1;
    if (sync_seen === 1'b1) n_sync++;
    chk("sync_seen", 32'(sync_seen), 32'(m_sync));
    chk("locked", 32'(locked), 32'(m_locked));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("ovf_count", 32'(ovf_count), 32'(m_cnt));
    chk("out_valid", 32'(bus.out_valid), 32'(m_full));
    chk("out_data", 32'(bus.out_data), 32'(m_data));
  endtask
  task automatic send_byte(input logic [7:0] b, input logic rdy, input int gap_max);
    for (int k = 0; k < 4; k++) begin
      repeat ($urandom_range(gap_max, 0)) step(1'b0, 2'($urandom), 1'b0, rdy);
      step(1'b1, b[2*k+:2], 1'b0, rdy);
    end
  endtask
  function automatic logic [7:0] rand_data();
    logic [7:0] b;
    do b = 8'($urandom); while (b == SYNC);
    return b;
  endfunction
  initial begin
    int s0;
    bus.out_ready = 1'b0;
    // reset values with random inputs
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'($urandom); ddr_in = 2'($urandom); bus.out_ready = 1'($urandom);
      @(posedge clk);
      #1;
      chk("rst_locked", 32'(locked), 0);
      chk("rst_sync", 32'(sync_seen), 0);
      chk("rst_ovf", 32'(overflow), 0);
      chk("rst_cnt", 32'(ovf_count), 0);
      chk("rst_valid", 32'(bus.out_valid), 0);
      chk("rst_data", 32'(bus.out_data), 0);
    end
    @(negedge clk);
    in_valid = 0; bus.out_ready = 0; reset_n = 1'b1;
    model_reset();
    // lock from a 2-bit offset, then one data word
    step(1'b1, 2'b01, 1'b0, 1'b1);
    send_byte(SYNC, 1'b1, 0);
    chk("lock_sync", 32'(sync_seen), 1);
    chk("lock_locked", 32'(locked), 1);
    send_byte(8'h3C, 1'b1, 0);
    chk("first_valid", 32'(bus.out_valid), 1);
    chk("first_data", 32'(bus.out_data), 32'h3C);
    step(1'b0, 2'b00, 1'b0, 1'b1);
    // idle words are dropped
    got_q.delete();
    s0 = n_sync;
    send_byte(SYNC, 1'b1, 0);
    send_byte(8'h5A, 1'b1, 0);
    send_byte(SYNC, 1'b1, 0);
    send_byte(SYNC, 1'b1, 0);
    repeat (2) step(1'b0, 2'b00, 1'b0, 1'b1);
    chk("idle_syncs", 32'(n_sync - s0), 3);
    chk("idle_words", 32'(got_q.size()), 1);
    if (got_q.size() > 0) chk("idle_word", 32'(got_q[0]), 32'h5A);
    // backpressure and overflow
    got_q.delete();
    send_byte(8'h11, 1'b0, 0);
    chk("bp_data11", 32'(bus.out_data), 32'h11);
    chk("bp_noovf", 32'(overflow), 0);
    send_byte(8'h22, 1'b0, 0);
    chk("bp_ovf", 32'(overflow), 1);
    chk("bp_cnt1", 32'(ovf_count), 1);
    chk("bp_hold11", 32'(bus.out_data), 32'h11);
    send_byte(8'h33, 1'b0, 0);
    chk("bp_cnt2", 32'(ovf_count), 2);
    step(1'b0, 2'b00, 1'b0, 1'b1);
    step(1'b0, 2'b00, 1'b0, 1'b1);
    chk("bp_words", 32'(got_q.size()), 1);
    if (got_q.size() > 0) chk("bp_word", 32'(got_q[0]), 32'h11);
    chk("bp_drained", 32'(bus.out_valid), 0);
    // throughput with random in_valid gaps
    got_q.delete();
    sent_q.delete();
    for (int i = 0; i < 24; i++) begin
      logic [7:0] b = rand_data();
      sent_q.push_back(b);
      send_byte(b, 1'b1, i % 3);
    end
    repeat (3) step(1'b0, 2'b00, 1'b0, 1'b1);
    chk("tp_count", 32'(got_q.size()), 32'(sent_q.size()));
    for (int i = 0; i < sent_q.size() && i < got_q.size(); i++) chk("tp_order", 32'(got_q[i]), 32'(sent_q[i]));
    chk("tp_cnt", 32'(ovf_count), 2);
    // counter saturation
    for (int i = 0; i < 300; i++) send_byte(rand_data(), 1'b0, 0);
    chk("sat_cnt", 32'(ovf_count), 32'hFF);
    chk("sat_ovf", 32'(overflow), 1);
    // resync mid-word with a pending word
    got_q.delete();
    sent_q.delete();
    sent_q.push_back(bus.out_data);
    step(1'b1, 2'b00, 1'b0, 1'b0);
    step(1'b1, 2'b00, 1'b0, 1'b0);
    step(1'b0, 2'b00, 1'b1, 1'b0);
    chk("rs_locked", 32'(locked), 0);
    chk("rs_ovf", 32'(overflow), 0);
    chk("rs_cnt", 32'(ovf_count), 32'hFF);
    chk("rs_pending", 32'(bus.out_valid), 1);
    step(1'b0, 2'b00, 1'b0, 1'b1);
    step(1'b1, 2'b01, 1'b0, 1'b1);
    send_byte(SYNC, 1'b1, 0);
    chk("relock", 32'(locked), 1);
    send_byte(8'h3C, 1'b1, 0);
    chk("relock_data", 32'(bus.out_data), 32'h3C);
    step(1'b0, 2'b00, 1'b0, 1'b1);
    chk("rs_words", 32'(got_q.size()), 2);
    if (got_q.size() == 2) begin
      chk("rs_word0", 32'(got_q[0]), 32'(sent_q[0]));
      chk("rs_word1", 32'(got_q[1]), 32'h3C);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
